imem_loader_responder: RTL
==========================

// Module: imem_loader_responder
// PURPOSE
//  Instruction-memory responder for the IF stage: answers i_IF_mem_ImemAddr with o_IF_mem_ImemDataR in the same cycle.
//  Owns the program store and a word-stream load port (valid/ready) that fills it before the core runs.
//  The FSM gates the core via o_SYS_ctrl_CoreRun (drives core nrst) and flags bad fetches.
// PARAMETERS
//  BASE_ADDR   32'h40020000  byte address of word 0 (first post-reset fetch target)
//  DEPTH_LOG2  10            log2 of store depth in 32-bit words (DEPTH = 2**DEPTH_LOG2)
//  NOP_WORD    32'h00000000  word returned for any fetch not served from the store
// PORTS
//  clk                    in   1   clock, all state on rising edge
//  nrst                   in   1   asynchronous active-low reset
//  i_IF_mem_ImemAddr      in   32  fetch byte address from IF
//  o_IF_mem_ImemDataR     out  32  fetched instruction, combinational from address and state
//  i_LD_start             in   1   begin (re)load: clear pointer, enter LOAD
//  i_LD_valid             in   1   load beat valid
//  i_LD_data              in   32  load beat instruction word
//  i_LD_last              in   1   final beat of program
//  o_LD_ready             out  1   store accepts a beat this cycle
//  o_SYS_ctrl_CoreRun     out  1   registered; 1 only in RUN
//  o_SYS_err_FetchFault   out  1   sticky fetch fault flag
//  o_SYS_data_LoadCount   out  DEPTH_LOG2+1  words loaded in current/last load
// BEHAVIOUR
//  Reset (nrst=0, async): state=IDLE, wptr=0, LoadCount=0, FetchFault=0, CoreRun=0. Store contents not reset.
//  States: IDLE, LOAD, RUN, OVF (2-bit encoding).
//   IDLE: i_LD_start -> LOAD. Else stay.
//   LOAD: beat accepted when i_LD_valid & o_LD_ready: mem[wptr]<=i_LD_data, wptr++, LoadCount++.
//         accepted beat with i_LD_last -> RUN. Accepted beat at wptr=DEPTH-1 without last -> OVF.
//         Last beat at wptr=DEPTH-1 -> RUN (full program, no overflow).
//   RUN:  CoreRun=1. i_LD_start -> LOAD.
//   OVF:  CoreRun=0, ready=0, store kept; only i_LD_start leaves (-> LOAD).
//  i_LD_start (any state): next state LOAD, wptr<=0, LoadCount<=0, FetchFault<=0; beat in that cycle not accepted.
//  o_LD_ready = (state==LOAD) & ~i_LD_start (combinational).
//  CoreRun registered: rises the cycle after the last beat is accepted; falls the cycle after i_LD_start.
//  Fetch: off = ImemAddr - BASE_ADDR (32-bit wrap); idx = off[DEPTH_LOG2+1:2].
//   Served (ImemDataR = mem[idx]) iff state==RUN, off[1:0]==0, off < 4*DEPTH, idx < LoadCount.
//   Otherwise ImemDataR = NOP_WORD. Latency 0; no handshake on fetch side.
//  FetchFault set (sticky) in RUN on unserved fetch, except ImemAddr == BASE_ADDR-4 (core reset PC, first cycle).
//   Causes: misaligned, below base, at/after 4*DEPTH, idx >= LoadCount. Cleared only by reset or i_LD_start.
//  Fetch outside RUN never sets FetchFault (core held in reset).
//  LoadCount saturates at DEPTH; wptr never wraps (OVF taken instead).
//  Reset mid-LOAD: load discarded (LoadCount=0); partially written words unreadable until reloaded.
// TESTING
//  Reset, then addr=BASE_ADDR -> DataR=0, CoreRun=0, FetchFault=0, ready=0.
//  start; 3 beats 0x11,0x22,0x33(last) back-to-back -> LoadCount=3, CoreRun=1 next cycle; addr BASE+4 -> 0x22.
//  RUN: addr 0x4001fffc -> NOP, no fault; addr BASE+12 (idx 3 >= count) -> NOP, FetchFault=1 next cycle, stays 1.
//  RUN: addr BASE+2 -> NOP, fault; then start -> FetchFault=0, CoreRun=0 next cycle, ready=0 during start cycle.
//  LOAD DEPTH beats, none last -> OVF after beat DEPTH, ready=0, CoreRun=0; DEPTH beats with last on final -> RUN.
//  valid toggled with gaps, start asserted with valid in LOAD -> that beat dropped, wptr=0; nrst pulse mid-load -> IDLE, count 0.

Source files
------------

// File: rtl/imem_loader_responder.sv
// Instruction-memory responder: zero-latency fetch port for IF plus a valid/ready
// word-stream loader that fills the program store and releases the core when done.
module imem_loader_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h40020000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [31:0]           i_IF_mem_ImemAddr,
  output logic [31:0]           o_IF_mem_ImemDataR,
  input  logic                  i_LD_start,
  input  logic                  i_LD_valid,
  input  logic [31:0]           i_LD_data,
  input  logic                  i_LD_last,
  output logic                  o_LD_ready,
  output logic                  o_SYS_ctrl_CoreRun,
  output logic                  o_SYS_err_FetchFault,
  output logic [DEPTH_LOG2:0]   o_SYS_data_LoadCount
);
  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_PTR = {1'b0, {DEPTH_LOG2{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OVF} state_t;

  state_t              state_q, state_d;
  // Load count doubles as the write pointer: both clear together and advance per beat.
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic                run_q;
  logic [31:0]         mem_q [DEPTH];

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  served;
  logic                  beat;

  assign off    = i_IF_mem_ImemAddr - BASE_ADDR;
  assign idx    = off[DEPTH_LOG2+1:2];
  assign served = (state_q == S_RUN) && (off[1:0] == 2'b00) &&
                  (off[31:DEPTH_LOG2+2] == '0) && ({1'b0, idx} < cnt_q);

  assign o_IF_mem_ImemDataR   = served ? mem_q[idx] : NOP_WORD;
  assign o_LD_ready           = (state_q == S_LOAD) & ~i_LD_start;
  assign beat                 = o_LD_ready & i_LD_valid;
  assign o_SYS_ctrl_CoreRun   = run_q;
  assign o_SYS_err_FetchFault = fault_q;
  assign o_SYS_data_LoadCount = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (i_LD_start) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else begin
      // BASE-4 is the PC the core presents while coming out of reset.
      if (state_q == S_RUN && !served && i_IF_mem_ImemAddr != BASE_ADDR - 32'd4)
        fault_d = 1'b1;
      if (beat) begin
        cnt_d = cnt_q + 1'b1;
        if (i_LD_last)              state_d = S_RUN;
        else if (cnt_q == LAST_PTR) state_d = S_OVF;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      run_q   <= (state_d == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) mem_q[cnt_q[DEPTH_LOG2-1:0]] <= i_LD_data;
  end
endmodule
